wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter_pkg.sv | 26 ++
 rtl/wb_fifo.sv | 61 ++++++
 rtl/wb_arbiter.sv | 150 +++++++++++++++
 tb/tb_wb_arbiter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arbiter_pkg.sv
// Shared types for the write-back arbiter: result payload and source identifiers.
package wb_arbiter_pkg;

    localparam int REG_W  = 5;
    localparam int DATA_W = 32;

    // One write-back result: destination register and the value to write.
    typedef struct packed {
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] data;
    } result_t;

    localparam int RESULT_W = $bits(result_t);

    // Result sources competing for the single register-file write port.
    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } src_e;

    // The source that should win a conflict, given who won the previous grant.
    function automatic src_e other_src(input src_e s);
        return (s == SRC_ALU) ? SRC_MEM : SRC_ALU;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO buffering ALU results until they win the write port.
// A push is also accepted while full if a pop happens in the same cycle.
module wb_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; the pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: buffers ALU results, round-robins them against the load
// unit onto one register-file write port, and tracks pending writes for hazards.
//
// Handshake: a result transfers on a rising edge when its valid and ready are
// both high in the cycle before; valid must hold with stable payload until then.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rd,
    input  logic [4:0]  src_a,
    input  logic [4:0]  src_b,
    output logic        hazard,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    output logic        alu_ready,
    input  logic        mem_valid,
    input  logic [4:0]  mem_rd,
    input  logic [31:0] mem_data,
    output logic        mem_ready,
    output logic        rf_load,
    output logic [4:0]  rf_dest,
    output logic [31:0] rf_in,
    output logic [31:0] busy
);

    result_t     alu_in;
    result_t     fifo_head;
    result_t     win;
    logic        fifo_full;
    logic        fifo_empty;
    logic        fifo_push;
    logic        grant_alu;
    logic        grant_mem;
    logic        grant_any;
    logic        rst_q;
    src_e        last_grant;
    src_e        last_grant_next;
    logic [31:0] busy_next;

    assign alu_in    = {alu_rd, alu_data};
    assign alu_ready = rst || !fifo_full;
    assign fifo_push = alu_valid && !fifo_full;
    assign mem_ready = grant_mem;
    assign grant_any = grant_alu || grant_mem;

    wb_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (RESULT_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (alu_in),
        .pop       (grant_alu),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Remember that reset was active last cycle; no grants are issued then.
    always_ff @(posedge clk) begin
        rst_q <= rst;
    end

    // Round-robin grant: on conflict the source not granted last wins.
    always_comb begin
        grant_alu       = 1'b0;
        grant_mem       = 1'b0;
        win             = '0;
        last_grant_next = last_grant;
        if (!rst && !rst_q) begin
            if (!fifo_empty && mem_valid) begin
                if (other_src(last_grant) == SRC_ALU) begin
                    grant_alu = 1'b1;
                end else begin
                    grant_mem = 1'b1;
                end
            end else if (!fifo_empty) begin
                grant_alu = 1'b1;
            end else if (mem_valid) begin
                grant_mem = 1'b1;
            end
        end
        if (grant_mem) begin
            win             = {mem_rd, mem_data};
            last_grant_next = SRC_MEM;
        end else if (grant_alu) begin
            win             = fifo_head;
            last_grant_next = SRC_ALU;
        end
    end

    // Arbiter state register; reset favours the load unit on the first conflict.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= SRC_ALU;
        end else begin
            last_grant <= last_grant_next;
        end
    end

    // Register-file write port; writes to r0 are consumed silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_load <= 1'b0;
            rf_dest <= '0;
            rf_in   <= '0;
        end else begin
            rf_load <= grant_any && (win.rd != '0);
            if (grant_any && (win.rd != '0)) begin
                rf_dest <= win.rd;
                rf_in   <= win.data;
            end
        end
    end

    // Pending-write scoreboard next state: clear on write-back, issue set wins.
    always_comb begin
        busy_next = busy;
        if (rf_load) begin
            busy_next[rf_dest] = 1'b0;
        end
        if (issue_valid && (issue_rd != '0)) begin
            busy_next[issue_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    // Hazard when either decode source waits on a pending write; r0 never does.
    always_comb begin
        hazard = !rst && (((src_a != '0) && busy[src_a]) ||
                          ((src_b != '0) && busy[src_b]));
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: source queues drive both result ports, a cycle model
// predicts ready/hazard/busy, and an expected queue holds each write-back.
module tb_wb_arbiter;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        issue_valid = 1'b0;
    logic [4:0]  issue_rd = '0;
    logic [4:0]  src_a = '0;
    logic [4:0]  src_b = '0;
    logic        hazard;
    logic        alu_valid = 1'b0;
    logic [4:0]  alu_rd = '0;
    logic [31:0] alu_data = '0;
    logic        alu_ready;
    logic        mem_valid = 1'b0;
    logic [4:0]  mem_rd = '0;
    logic [31:0] mem_data = '0;
    logic        mem_ready;
    logic        rf_load;
    logic [4:0]  rf_dest;
    logic [31:0] rf_in;
    logic [31:0] busy;

    // Stimulus sources ({rd, data}) and the model state.
    logic [36:0] alu_src_q[$];
    logic [36:0] mem_src_q[$];
    logic [36:0] model_fifo[$];
    logic [37:0] exp_q[$];          // {load, rd, data} expected one cycle later
    logic [31:0] model_busy = '0;
    logic        model_last_mem = 1'b0;
    logic        model_boot = 1'b1;

    int checks = 0;
    int errors = 0;

    wb_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .src_a       (src_a),
        .src_b       (src_b),
        .hazard      (hazard),
        .alu_valid   (alu_valid),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .alu_ready   (alu_ready),
        .mem_valid   (mem_valid),
        .mem_rd      (mem_rd),
        .mem_data    (mem_data),
        .mem_ready   (mem_ready),
        .rf_load     (rf_load),
        .rf_dest     (rf_dest),
        .rf_in       (rf_in),
        .busy        (busy)
    );

    // Clock.
    always #5 clk = ~clk;

    // Watchdog.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (checks=%0d errors=%0d)", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive, check against the model, advance the model.
    task automatic cycle();
        logic [37:0] cur;
        logic [36:0] res;
        logic        have_cur;
        logic        exp_alu_ready;
        logic        alu_req;
        logic        mem_req;
        logic        ga;
        logic        gm;
        logic        exp_hazard;

        alu_valid = (alu_src_q.size() > 0);
        {alu_rd, alu_data} = alu_valid ? alu_src_q[0] : 37'd0;
        mem_valid = (mem_src_q.size() > 0);
        {mem_rd, mem_data} = mem_valid ? mem_src_q[0] : 37'd0;
        #1;

        have_cur = 1'b0;
        cur = '0;
        if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            have_cur = 1'b1;
        end
        if (have_cur) begin
            check("rf_load", 32'(rf_load), 32'(cur[37]));
            if (cur[37]) begin
                check("rf_dest", 32'(rf_dest), 32'(cur[36:32]));
                check("rf_in", rf_in, cur[31:0]);
            end
        end
        check("busy", busy, model_busy);

        if (rst) begin
            check("alu_ready_rst", 32'(alu_ready), 32'd1);
            check("mem_ready_rst", 32'(mem_ready), 32'd0);
            check("hazard_rst", 32'(hazard), 32'd0);
            model_fifo.delete();
            model_busy = '0;
            model_last_mem = 1'b0;
            exp_q.delete();
            exp_q.push_back(38'd0);
            model_boot = 1'b1;
        end else begin
            exp_alu_ready = (model_fifo.size() < DEPTH);
            alu_req = (model_fifo.size() > 0) && !model_boot;
            mem_req = mem_valid && !model_boot;
            ga = 1'b0;
            gm = 1'b0;
            if (alu_req && mem_req) begin
                if (model_last_mem) ga = 1'b1;
                else gm = 1'b1;
            end else if (alu_req) begin
                ga = 1'b1;
            end else if (mem_req) begin
                gm = 1'b1;
            end
            exp_hazard = ((src_a != 0) && model_busy[src_a]) || ((src_b != 0) && model_busy[src_b]);
            check("alu_ready", 32'(alu_ready), 32'(exp_alu_ready));
            check("mem_ready", 32'(mem_ready), 32'(gm));
            check("hazard", 32'(hazard), 32'(exp_hazard));

            if (have_cur && cur[37]) model_busy[cur[36:32]] = 1'b0;
            if (issue_valid && issue_rd != 0) model_busy[issue_rd] = 1'b1;

            res = '0;
            if (gm) res = {mem_rd, mem_data};
            else if (ga) res = model_fifo.pop_front();
            if (ga || gm) exp_q.push_back({(res[36:32] != 5'd0), res});
            else exp_q.push_back(38'd0);

            if (alu_valid && exp_alu_ready) model_fifo.push_back({alu_rd, alu_data});
            if (gm) model_last_mem = 1'b1;
            else if (ga) model_last_mem = 1'b0;
            model_boot = 1'b0;
        end

        if (alu_valid && alu_ready) void'(alu_src_q.pop_front());
        if (mem_valid && mem_ready) void'(mem_src_q.pop_front());
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int n = 0; n < 100; n++) begin
            if (alu_src_q.size() == 0 && mem_src_q.size() == 0 && model_fifo.size() == 0) break;
            cycle();
        end
        check("drain_alu_src", 32'(alu_src_q.size()), 32'd0);
        check("drain_mem_src", 32'(mem_src_q.size()), 32'd0);
        repeat (2) cycle();
    endtask

    initial begin
        // Reset with a load result already offered; it must wait.
        mem_src_q.push_back({5'd3, 32'h0000_0033});
        @(posedge clk);
        #1;
        repeat (2) cycle();
        rst = 1'b0;
        cycle();
        repeat (2) cycle();

        // Issue r5, then its ALU result; hazard on src_a follows busy[5].
        issue_valid = 1'b1;
        issue_rd = 5'd5;
        src_a = 5'd5;
        cycle();
        issue_valid = 1'b0;
        alu_src_q.push_back({5'd5, 32'hDEADBEEF});
        repeat (4) cycle();
        check("busy5_cleared", 32'(busy[5]), 32'd0);
        src_a = 5'd0;

        // Both sources every cycle: writes alternate MEM, ALU, ...
        for (int i = 1; i <= 4; i++) begin
            alu_src_q.push_back({5'(i), 32'hA000_0000 + 32'(i)});
            mem_src_q.push_back({5'(i), 32'hB000_0000 + 32'(i)});
        end
        repeat (12) cycle();

        // Load unit streaming while the ALU floods its buffer.
        for (int i = 0; i < 4; i++) begin
            mem_src_q.push_back({5'(8 + i), 32'hC000_0000 + 32'(i)});
            alu_src_q.push_back({5'(12 + i), 32'hD000_0000 + 32'(i)});
        end
        repeat (12) cycle();

        // Result for r0 is consumed without a write.
        src_b = 5'd0;
        alu_src_q.push_back({5'd0, 32'h0000_1234});
        repeat (3) cycle();
        check("busy0", 32'(busy[0]), 32'd0);

        // Issue r7 in the same cycle its earlier write-back happens.
        issue_valid = 1'b1;
        issue_rd = 5'd7;
        cycle();
        issue_valid = 1'b0;
        alu_src_q.push_back({5'd7, 32'h0000_7777});
        cycle();
        cycle();
        issue_valid = 1'b1;
        issue_rd = 5'd7;
        cycle();
        issue_valid = 1'b0;
        check("busy7_set_wins", 32'(busy[7]), 32'd1);
        repeat (2) cycle();

        // Random traffic.
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 2) == 0 && alu_src_q.size() < 4)
                alu_src_q.push_back({5'($urandom_range(0, 31)), 32'($urandom)});
            if ($urandom_range(0, 2) == 0 && mem_src_q.size() < 4)
                mem_src_q.push_back({5'($urandom_range(0, 31)), 32'($urandom)});
            issue_valid = ($urandom_range(0, 3) == 0);
            issue_rd = 5'($urandom_range(0, 31));
            src_a = 5'($urandom_range(0, 31));
            src_b = 5'($urandom_range(0, 31));
            cycle();
        end
        issue_valid = 1'b0;
        drain();

        // Reset with two buffered ALU results and a write in flight.
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            alu_src_q.push_back({5'(20 + i), 32'hE000_0000 + 32'(i)});
            mem_src_q.push_back({5'(23 + i), 32'hF000_0000 + 32'(i)});
        end
        issue_valid = 1'b1;
        issue_rd = 5'd9;
        cycle();
        issue_valid = 1'b0;
        cycle();
        alu_src_q.delete();
        mem_src_q.delete();
        src_a = 5'd9;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("busy_after_rst", busy, 32'd0);
        check("rf_load_after_rst", 32'(rf_load), 32'd0);
        check("alu_ready_after_rst", 32'(alu_ready), 32'd1);
        repeat (4) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
